// File: rtl/bitstream_pkg.sv
// ---------------------------------------------------------------------------
// bitstream_pkg
// Definitions shared by the stochastic bitstream encoders and decoders:
// decoder state encoding, counter width helper and the default stream length.
// ---------------------------------------------------------------------------
package bitstream_pkg;

    // Default window length, shared with the encoders (integer scale 0..255).
    localparam int STREAM_LENGTH = 255;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } dec_state_t;

    // Width needed to hold 0..length inclusive.
    function automatic int cnt_width(input int length);
        return $clog2(length + 1);
    endfunction

endpackage

// File: rtl/bitstream_decoder.sv
// ---------------------------------------------------------------------------
// bitstream_decoder
// Counts ones over a window of LENGTH valid bits and converts the count to a
// signed integer: unipolar gives value = ones, bipolar gives
// value = 2*ones - LENGTH. Windows are started by a start pulse (one-shot) or
// chained with no dead cycle when cont is high at the end of a window.
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   start       begins a window when idle, ignored while running
//   cont        sampled on the last bit: restart immediately when high
//   clear       synchronous abort to idle, overrides start and bits
//   bit_in      stochastic bit
//   bit_valid   qualifies bit_in; low stalls the window
//   busy        high while a window is running
//   value       signed result of the last completed window
//   value_valid one-cycle strobe when value updates
// ---------------------------------------------------------------------------
module bitstream_decoder
    import bitstream_pkg::*;
#(
    parameter int LENGTH  = STREAM_LENGTH,
    parameter bit BIPOLAR = 1'b0,
    parameter int OUT_W   = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    cont,
    input  logic                    clear,
    input  logic                    bit_in,
    input  logic                    bit_valid,
    output logic                    busy,
    output logic signed [OUT_W-1:0] value,
    output logic                    value_valid
);

    localparam int CW = cnt_width(LENGTH);

    if (LENGTH < 2 || LENGTH > 65535 || OUT_W < cnt_width(LENGTH) + 2) begin : g_param_check
        $fatal(1, "bitstream_decoder: LENGTH must be 2..65535 and OUT_W >= clog2(LENGTH+1)+2");
    end

    dec_state_t     state;
    logic [CW-1:0]  bit_cnt;
    logic [CW-1:0]  ones;

    logic           last_bit;
    logic [CW-1:0]  total;
    logic [OUT_W-1:0] total_ext;
    logic [OUT_W-1:0] result;

    assign last_bit  = (bit_cnt == CW'(LENGTH - 1));
    assign total     = ones + CW'(bit_in);
    assign total_ext = OUT_W'(total);
    // Two's-complement wraparound gives the signed 2*total - LENGTH directly;
    // OUT_W has two bits of headroom so the result never overflows.
    assign result    = BIPOLAR ? ((total_ext << 1) - OUT_W'(LENGTH)) : total_ext;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            ones        <= '0;
            busy        <= 1'b0;
            value       <= '0;
            value_valid <= 1'b0;
        end else begin
            value_valid <= 1'b0;
            if (clear) begin
                state   <= IDLE;
                busy    <= 1'b0;
                bit_cnt <= '0;
                ones    <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        // Any bit arriving alongside start belongs to no window.
                        if (start) begin
                            state   <= RUN;
                            busy    <= 1'b1;
                            bit_cnt <= '0;
                            ones    <= '0;
                        end
                    end
                    RUN: begin
                        if (bit_valid) begin
                            if (last_bit) begin
                                value       <= $signed(result);
                                value_valid <= 1'b1;
                                bit_cnt     <= '0;
                                ones        <= '0;
                                if (!cont) begin
                                    state <= IDLE;
                                    busy  <= 1'b0;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + CW'(1);
                                ones    <= total;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bitstream_decoder.sv
// ---------------------------------------------------------------------------
// tb_bitstream_decoder
// Drives a unipolar and a bipolar decoder (LENGTH 255) from the same stimulus.
// Windows are built as shuffled arrays with a known number of ones; the
// expected result of a window is that count (unipolar) or 2*count-255
// (bipolar), due exactly one cycle after the last valid bit.
// ---------------------------------------------------------------------------
module tb_bitstream_decoder;

    localparam int LEN = 255;

    logic clk = 1'b0;
    logic rst, start, cont, clear, bit_in, bit_valid;
    logic busy_u, busy_b, vv_u, vv_b;
    logic signed [31:0] val_u, val_b;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic win[LEN];

    typedef struct {
        int   cyc;
        int   uv;
        int   bv;
        logic both;
        logic bu;
        logic bb;
    } strobe_t;
    strobe_t sq[$];

    bit watch_busy   = 1'b0;
    bit busy_dropped = 1'b0;

    bitstream_decoder #(.LENGTH(LEN), .BIPOLAR(1'b0), .OUT_W(32)) u_uni (
        .clk(clk), .rst(rst), .start(start), .cont(cont), .clear(clear),
        .bit_in(bit_in), .bit_valid(bit_valid),
        .busy(busy_u), .value(val_u), .value_valid(vv_u)
    );

    bitstream_decoder #(.LENGTH(LEN), .BIPOLAR(1'b1), .OUT_W(32)) u_bip (
        .clk(clk), .rst(rst), .start(start), .cont(cont), .clear(clear),
        .bit_in(bit_in), .bit_valid(bit_valid),
        .busy(busy_b), .value(val_b), .value_valid(vv_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe recorder: at each falling edge, cyc equals the number of rising
    // edges so far, so a strobe produced by edge N is logged with cyc == N.
    always @(negedge clk) begin
        if (vv_u || vv_b)
            sq.push_back('{cyc, int'(val_u), int'(val_b), vv_u & vv_b, busy_u, busy_b});
        if (watch_busy && !(busy_u && busy_b))
            busy_dropped <= 1'b1;
    end

    task automatic drive(input logic s, input logic c, input logic cl, input logic b, input logic v);
        @(negedge clk);
        start = s; cont = c; clear = cl; bit_in = b; bit_valid = v;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Start pulse carrying a valid 1 that must not be counted.
    task automatic do_start();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic make_window(input int k);
        logic t;
        int   j;
        for (int i = 0; i < LEN; i++) win[i] = (i < k);
        for (int i = LEN - 1; i > 0; i--) begin
            j = $urandom_range(i);
            t = win[i]; win[i] = win[j]; win[j] = t;
        end
    endtask

    // Sends the first n bits of win, with random stall cycles; returns the
    // rising-edge index at which the final bit is sampled.
    task automatic send_bits(input int n, input int stall_pct, input logic cont_end,
                             output int last_edge);
        int st;
        for (int i = 0; i < n; i++) begin
            st = 0;
            while (st < 20 && stall_pct > 0 && $urandom_range(99) < stall_pct) begin
                drive(1'($urandom_range(1)), 1'($urandom_range(1)), 1'b0,
                      1'($urandom_range(1)), 1'b0);
                st++;
            end
            drive(1'($urandom_range(1)), (i == n - 1) ? cont_end : 1'($urandom_range(1)),
                  1'b0, win[i], 1'b1);
        end
        last_edge = cyc + 1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 0; cont = 0; clear = 0; bit_in = 0; bit_valid = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy_u, busy_b, vv_u, vv_b} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got busy=%b%b valid=%b%b expected 0000", busy_u, busy_b, vv_u, vv_b);
        end
        checks++;
        if (val_u !== 32'sd0) begin
            errors++; $display("FAIL reset_value_uni: got %0d expected 0", val_u);
        end
        checks++;
        if (val_b !== 32'sd0) begin
            errors++; $display("FAIL reset_value_bip: got %0d expected 0", val_b);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_unipolar_oneshot();
        int le;
        sq.delete();
        make_window(124);
        do_start();
        @(posedge clk); #1;
        checks++;
        if (busy_u !== 1'b1) begin
            errors++; $display("FAIL busy_rise: got %b expected 1", busy_u);
        end
        send_bits(LEN, 0, 1'b0, le);
        idle(3);
        checks++;
        if (sq.size() !== 1) begin
            errors++; $display("FAIL oneshot_strobes: got %0d expected 1", sq.size());
        end else begin
            checks++;
            if (sq[0].cyc !== le) begin
                errors++; $display("FAIL oneshot_latency: got edge %0d expected %0d", sq[0].cyc, le);
            end
            checks++;
            if (sq[0].uv !== 124) begin
                errors++; $display("FAIL oneshot_value: got %0d expected 124", sq[0].uv);
            end
            checks++;
            if (sq[0].bu !== 1'b0) begin
                errors++; $display("FAIL oneshot_busy_drop: got %b expected 0", sq[0].bu);
            end
        end
        checks++;
        if (val_u !== 32'sd124) begin
            errors++; $display("FAIL oneshot_hold: got %0d expected 124", val_u);
        end
    endtask

    // Three one-shot windows, each new start issued in the strobe cycle.
    task automatic test_bipolar();
        int ks[3] = '{255, 0, 128};
        int le[3];
        sq.delete();
        do_start();
        for (int w = 0; w < 3; w++) begin
            make_window(ks[w]);
            send_bits(LEN, 0, 1'b0, le[w]);
            if (w < 2) do_start();
        end
        idle(3);
        checks++;
        if (sq.size() !== 3) begin
            errors++; $display("FAIL bipolar_strobes: got %0d expected 3", sq.size());
        end else begin
            for (int w = 0; w < 3; w++) begin
                checks++;
                if (sq[w].bv !== 2 * ks[w] - LEN) begin
                    errors++; $display("FAIL bipolar_value[%0d]: got %0d expected %0d", w, sq[w].bv, 2 * ks[w] - LEN);
                end
                checks++;
                if (sq[w].uv !== ks[w] || sq[w].both !== 1'b1) begin
                    errors++; $display("FAIL bipolar_uni[%0d]: got %0d/%b expected %0d/1", w, sq[w].uv, sq[w].both, ks[w]);
                end
                checks++;
                if (sq[w].cyc !== le[w]) begin
                    errors++; $display("FAIL bipolar_latency[%0d]: got edge %0d expected %0d", w, sq[w].cyc, le[w]);
                end
            end
        end
    endtask

    task automatic test_stalls();
        int le;
        sq.delete();
        make_window(82);
        do_start();
        send_bits(LEN, 40, 1'b0, le);
        idle(3);
        checks++;
        if (sq.size() !== 1) begin
            errors++; $display("FAIL stall_strobes: got %0d expected 1", sq.size());
        end else begin
            checks++;
            if (sq[0].cyc !== le) begin
                errors++; $display("FAIL stall_latency: got edge %0d expected %0d", sq[0].cyc, le);
            end
            checks++;
            if (sq[0].uv !== 82 || sq[0].bv !== 2 * 82 - LEN) begin
                errors++; $display("FAIL stall_value: got %0d/%0d expected 82/%0d", sq[0].uv, sq[0].bv, 2 * 82 - LEN);
            end
        end
    endtask

    task automatic test_continuous();
        int ks[3] = '{10, 200, 255};
        int le[3];
        sq.delete();
        busy_dropped = 1'b0;
        do_start();
        @(posedge clk); #1;
        watch_busy = 1'b1;
        for (int w = 0; w < 3; w++) begin
            make_window(ks[w]);
            send_bits(LEN, 0, (w < 2) ? 1'b1 : 1'b0, le[w]);
        end
        watch_busy = 1'b0;
        idle(3);
        checks++;
        if (busy_dropped !== 1'b0) begin
            errors++; $display("FAIL cont_busy: got drop=%b expected 0", busy_dropped);
        end
        checks++;
        if (busy_u !== 1'b0) begin
            errors++; $display("FAIL cont_final_idle: got busy=%b expected 0", busy_u);
        end
        checks++;
        if (sq.size() !== 3) begin
            errors++; $display("FAIL cont_strobes: got %0d expected 3", sq.size());
        end else begin
            for (int w = 0; w < 3; w++) begin
                checks++;
                if (sq[w].uv !== ks[w] || sq[w].bv !== 2 * ks[w] - LEN) begin
                    errors++; $display("FAIL cont_value[%0d]: got %0d/%0d expected %0d/%0d", w, sq[w].uv, sq[w].bv, ks[w], 2 * ks[w] - LEN);
                end
                checks++;
                if (sq[w].cyc !== le[w]) begin
                    errors++; $display("FAIL cont_latency[%0d]: got edge %0d expected %0d", w, sq[w].cyc, le[w]);
                end
                if (w > 0) begin
                    checks++;
                    if (sq[w].cyc - sq[w-1].cyc !== LEN) begin
                        errors++; $display("FAIL cont_spacing[%0d]: got %0d expected %0d", w, sq[w].cyc - sq[w-1].cyc, LEN);
                    end
                end
            end
        end
    endtask

    // Runs after test_continuous, whose last window held 255 ones.
    task automatic test_abort();
        int le;
        sq.delete();
        make_window($urandom_range(30, 220));
        do_start();
        send_bits(100, 0, 1'b0, le);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        idle(2);
        checks++;
        if (busy_u !== 1'b0 || busy_b !== 1'b0) begin
            errors++; $display("FAIL abort_busy: got %b%b expected 00", busy_u, busy_b);
        end
        checks++;
        if (sq.size() !== 0) begin
            errors++; $display("FAIL abort_strobe: got %0d strobes expected 0", sq.size());
        end
        checks++;
        if (val_u !== 32'sd255 || val_b !== 32'sd255) begin
            errors++; $display("FAIL abort_hold: got %0d/%0d expected 255/255", val_u, val_b);
        end
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        @(posedge clk); #1;
        checks++;
        if (busy_u !== 1'b0) begin
            errors++; $display("FAIL clear_beats_start: got busy=%b expected 0", busy_u);
        end
        make_window(50);
        do_start();
        send_bits(LEN, 0, 1'b0, le);
        idle(3);
        checks++;
        if (sq.size() !== 1) begin
            errors++; $display("FAIL abort_fresh_strobes: got %0d expected 1", sq.size());
        end else begin
            checks++;
            if (sq[0].uv !== 50 || sq[0].bv !== 2 * 50 - LEN || sq[0].cyc !== le) begin
                errors++; $display("FAIL abort_fresh_value: got %0d/%0d@%0d expected 50/%0d@%0d", sq[0].uv, sq[0].bv, sq[0].cyc, 2 * 50 - LEN, le);
            end
        end
    endtask

    task automatic test_reset_mid();
        int le;
        int k;
        sq.delete();
        make_window($urandom_range(20, 230));
        do_start();
        send_bits(130, 0, 1'b0, le);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({busy_u, busy_b, vv_u, vv_b} !== 4'b0000 || val_u !== 32'sd0 || val_b !== 32'sd0) begin
            errors++;
            $display("FAIL reset_mid: got busy=%b%b valid=%b%b value=%0d/%0d expected all 0", busy_u, busy_b, vv_u, vv_b, val_u, val_b);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        k = $urandom_range(0, LEN);
        make_window(k);
        do_start();
        send_bits(LEN, 20, 1'b0, le);
        idle(3);
        checks++;
        if (sq.size() !== 1) begin
            errors++; $display("FAIL reset_after_strobes: got %0d expected 1", sq.size());
        end else begin
            checks++;
            if (sq[0].uv !== k || sq[0].bv !== 2 * k - LEN || sq[0].cyc !== le) begin
                errors++; $display("FAIL reset_after_value: got %0d/%0d@%0d expected %0d/%0d@%0d", sq[0].uv, sq[0].bv, sq[0].cyc, k, 2 * k - LEN, le);
            end
        end
    endtask

    initial begin
        test_reset();
        test_unipolar_oneshot();
        test_bipolar();
        test_stalls();
        test_continuous();
        test_abort();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
